// File: rtl/junction_sequencer_if.sv
// junction_sequencer_if: control and status bundle shared by the top-level FSM,
// the tracker decode, the motor mode input and the junction sequencer.
interface junction_sequencer_if #(
    parameter int unsigned STACK_AW = 4
);
    logic                en;
    logic [2:0]          detect;
    logic                junction;
    logic                dead_end;
    logic [2:0]          mode;
    logic                busy;
    logic                done;
    logic [1:0]          dir;
    logic [STACK_AW:0]   depth;
    logic                err;

    // Controller side: drives enable, sensor code and event pulses.
    modport master (
        output en, detect, junction, dead_end,
        input  mode, busy, done, dir, depth, err
    );

    // Sequencer side.
    modport slave (
        input  en, detect, junction, dead_end,
        output mode, busy, done, dir, depth, err
    );
endinterface

// File: rtl/junction_sequencer.sv
// junction_sequencer: left-hand-first depth-first maze policy with a decision
// stack; times advance/spin/U-turn manoeuvres and returns control with a done pulse.
// Optional feature: define JSEQ_TIMEOUT_EN to send an over-long SPIN/UTURN to ERR.
module junction_sequencer #(
    parameter int unsigned ADVANCE_CYC      = 25_000_000,
    parameter int unsigned SPIN_MIN_CYC     = 10_000_000,
    parameter int unsigned SPIN_TIMEOUT_CYC = 200_000_000,
    parameter int unsigned STACK_DEPTH      = 16,
    parameter int unsigned STACK_AW         = 4
) (
    input  logic                clk,
    input  logic                rst,
    junction_sequencer_if.slave js
);
    // Counter wide enough for the longest interval it ever has to reach.
    localparam int unsigned CNT_MAX0 = (ADVANCE_CYC > SPIN_MIN_CYC) ? ADVANCE_CYC : SPIN_MIN_CYC;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > SPIN_TIMEOUT_CYC) ? CNT_MAX0 : SPIN_TIMEOUT_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned DEPTH_W  = STACK_AW + 1;

    localparam logic [2:0] MODE_STOP   = 3'd0;
    localparam logic [2:0] MODE_FWD    = 3'd1;
    localparam logic [2:0] MODE_SPIN_L = 3'd2;
    localparam logic [2:0] MODE_SPIN_R = 3'd3;

    localparam logic [1:0] DIR_LEFT     = 2'd0;
    localparam logic [1:0] DIR_STRAIGHT = 2'd1;
    localparam logic [1:0] DIR_RIGHT    = 2'd2;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_ADVANCE, S_SPIN, S_UTURN, S_DONE, S_ERR
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 bt_q, bt_d;
    logic                 straight_q, straight_d;
    logic [1:0]           dir_q, dir_d;
    logic [2:0]           mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           stack_q [STACK_DEPTH];

    logic                 push, upd;
    logic [1:0]           upd_val;
    logic [STACK_AW-1:0]  top_idx, below_idx, push_idx;
    logic [1:0]           top_val;
    logic                 accept;

    assign top_idx   = STACK_AW'(depth_q - DEPTH_W'(1));
    assign below_idx = STACK_AW'(depth_q - DEPTH_W'(2));
    assign push_idx  = STACK_AW'(depth_q);
    assign top_val   = stack_q[top_idx];
    // Line reacquired only once the old line has been cleared.
    assign accept    = (cnt_q >= CNT_W'(SPIN_MIN_CYC - 1)) && (js.detect == 3'b010);

    // Next-state, stack control and registered-output decode.
    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        bt_d       = bt_q;
        straight_d = straight_q;
        dir_d      = dir_q;
        push       = 1'b0;
        upd        = 1'b0;
        upd_val    = top_val + 2'd1;

        case (state_q)
            S_IDLE: begin
                if (js.junction) begin
                    if (!bt_q) begin
                        if (depth_q == DEPTH_FULL) begin
                            state_d = S_ERR;
                        end else begin
                            push       = 1'b1;
                            depth_d    = depth_q + DEPTH_W'(1);
                            dir_d      = DIR_LEFT;
                            straight_d = 1'b0;
                            state_d    = S_ADVANCE;
                        end
                    end else if (depth_q == '0) begin
                        state_d = S_ERR;
                    end else if (top_val == DIR_RIGHT) begin
                        // Branch exhausted: drop it and keep retreating.
                        depth_d    = depth_q - DEPTH_W'(1);
                        dir_d      = (depth_q == DEPTH_W'(1)) ? DIR_LEFT : stack_q[below_idx];
                        straight_d = 1'b0;
                        state_d    = S_ADVANCE;
                    end else begin
                        upd        = 1'b1;
                        dir_d      = upd_val;
                        bt_d       = 1'b0;
                        straight_d = (upd_val == DIR_STRAIGHT);
                        state_d    = S_ADVANCE;
                    end
                end else if (js.dead_end) begin
                    if (depth_q == '0) begin
                        state_d = S_ERR;
                    end else begin
                        bt_d    = 1'b1;
                        state_d = S_UTURN;
                    end
                end
            end
            S_ADVANCE: begin
                if (cnt_q == CNT_W'(ADVANCE_CYC - 1)) begin
                    state_d = straight_q ? S_DONE : S_SPIN;
                end
            end
            S_SPIN, S_UTURN: begin
                if (accept) begin
                    state_d = S_DONE;
                end
`ifdef JSEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(SPIN_TIMEOUT_CYC - 1)) begin
                    state_d = S_ERR;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        if (!js.en) begin
            state_d    = S_IDLE;
            depth_d    = '0;
            bt_d       = 1'b0;
            straight_d = 1'b0;
            dir_d      = DIR_LEFT;
            push       = 1'b0;
            upd        = 1'b0;
        end

        // Cleared on every state entry, saturating otherwise.
        if (!js.en || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        mode_d = MODE_STOP;
        case (state_d)
            S_ADVANCE: mode_d = MODE_FWD;
            S_SPIN:    mode_d = MODE_SPIN_L;
            S_UTURN:   mode_d = MODE_SPIN_R;
            default:   mode_d = MODE_STOP;
        endcase
        busy_d = (state_d == S_ADVANCE) || (state_d == S_SPIN) ||
                 (state_d == S_UTURN)   || (state_d == S_DONE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    // State, stack and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            depth_q    <= '0;
            bt_q       <= 1'b0;
            straight_q <= 1'b0;
            dir_q      <= DIR_LEFT;
            mode_q     <= MODE_STOP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= DIR_LEFT;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            depth_q    <= depth_d;
            bt_q       <= bt_d;
            straight_q <= straight_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (push) begin
                stack_q[push_idx] <= DIR_LEFT;
            end else if (upd) begin
                stack_q[top_idx] <= upd_val;
            end
        end
    end

    assign js.mode  = mode_q;
    assign js.busy  = busy_q;
    assign js.done  = done_q;
    assign js.dir   = dir_q;
    assign js.depth = depth_q;
    assign js.err   = err_q;
endmodule
